data_mem_responder: RTL and testbench

Responder side of the pipeline's data-memory access interface. It accepts one load/store request at a time from the memory-access stage through a valid/ready handshake and applies byte/half/word sizing, byte-lane write masking and load sign/zero extension. It returns a response through a second valid/ready handshake after a configurable number of wait states. It replaces the zero-latency behavioural data array, so the pipeline can be exercised against a memory that stalls.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/data_mem_responder_if.sv | 39 +++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory access path: the access-size encoding
// (same encoding as MemSize, also used by the control unit and mem_access) and
// the responder FSM state type.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;  // reserved encoding, always an error

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response handshake bundle between the memory-access stage (master)
// and the data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_wen             : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_sign            : load extension, 1 = sign, 0 = zero
//   req_wdata           : right-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_err             : misaligned, illegal size or out-of-range request
// -----------------------------------------------------------------------------
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_sign, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_sign, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for one 32-bit memory word.
//   size, addr_lo : access size and byte offset within the word
//   wdata         : right-aligned store data
//   sign          : load extension select
//   rword         : word read from the array
//   be            : byte enables for a store
//   wword         : store data replicated into the selected lanes
//   rdata         : load value shifted down and extended
//   misalign      : half on odd address or word on non-word address
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        sign,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic s);
    logic signed [7:0] sv;
    sv = v;
    return s ? 32'(sv) : 32'(v);
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic s);
    logic signed [15:0] sv;
    sv = v;
    return s ? 32'(sv) : 32'(v);
  endfunction

  logic [31:0] shifted;

  always_comb begin
    shifted  = rword >> {addr_lo, 3'b000};
    be       = 4'b0000;
    wword    = wdata;
    rdata    = 32'd0;
    misalign = 1'b0;
    case (size)
      SIZE_B: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = ext8(shifted[7:0], sign);
      end
      SIZE_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rdata    = ext16(shifted[15:0], sign);
        misalign = addr_lo[0];
      end
      SIZE_W: begin
        be       = 4'b1111;
        rdata    = shifted;
        misalign = |addr_lo;
      end
      default: begin
        be    = 4'b0000;
        rdata = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data-memory responder with LATENCY wait states.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (control and response registers only;
//          the word array keeps its contents)
//   bus  : slave side of data_mem_responder_if
// A request is accepted in IDLE, completes (memory read or write) on a single
// edge LATENCY cycles later (same edge for LATENCY=0), and the registered
// response is held in RESP until rsp_ready.
// -----------------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int         AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, complete, rsp_hs;

  logic        l_wen, l_sign;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;

  logic        cur_wen, cur_sign;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;

  logic [AW-1:0] idx;
  logic [31:0]   rword, wword, ld_val;
  logic [3:0]    be;
  logic          misalign, oor, err;

  logic [31:0] mem [DEPTH_WORDS];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: if (rsp_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / strobe decode; req_ready depends on state only
  always_comb begin
    bus.req_ready = (state == ST_IDLE);
    accept        = (state == ST_IDLE) && bus.req_valid;
    rsp_hs        = (state == ST_RESP) && bus.rsp_ready;
    complete      = (accept && (LATENCY == 0)) || ((state == ST_WAIT) && (cnt == 4'd1));
  end

  // With LATENCY=0 completion happens on the acceptance edge, before the
  // latches hold the request, so the live bus fields are used in IDLE.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_wen   = bus.req_wen;
      cur_sign  = bus.req_sign;
      cur_size  = bus.req_size;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_wen   = l_wen;
      cur_sign  = l_sign;
      cur_size  = l_size;
      cur_addr  = l_addr;
      cur_wdata = l_wdata;
    end
  end

  assign idx   = cur_addr[AW+1:2];
  assign oor   = cur_addr[31:2] >= 30'(DEPTH_WORDS);
  assign rword = mem[idx];
  assign err   = oor || misalign || (cur_size == SIZE_X);

  mem_lane_align u_align (
    .size     (cur_size),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .sign     (cur_sign),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_val),
    .misalign (misalign)
  );

  // Request capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      l_wen   <= bus.req_wen;
      l_sign  <= bus.req_sign;
      l_size  <= bus.req_size;
      l_addr  <= bus.req_addr;
      l_wdata <= bus.req_wdata;
    end
  end

  // Wait counter and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 4'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (accept)                 cnt <= LAT;
      else if (state == ST_WAIT)  cnt <= cnt - 4'd1;
      if (complete) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (err || cur_wen) ? 32'd0 : ld_val;
      end else if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

  // Word array; a store commits only on its completion edge
  always_ff @(posedge clk) begin
    if (complete && !rst && cur_wen && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder. dut_a runs with LATENCY=2, dut_b with
// LATENCY=4; "sel" routes the shared request drive and the observed outputs to
// one of them.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        req_valid, req_wen, req_sign, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  int checks = 0;
  int errors = 0;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  assign ifa.req_valid = req_valid & ~sel;
  assign ifb.req_valid = req_valid & sel;
  assign ifa.req_wen   = req_wen;   assign ifb.req_wen   = req_wen;
  assign ifa.req_addr  = req_addr;  assign ifb.req_addr  = req_addr;
  assign ifa.req_size  = req_size;  assign ifb.req_size  = req_size;
  assign ifa.req_sign  = req_sign;  assign ifb.req_sign  = req_sign;
  assign ifa.req_wdata = req_wdata; assign ifb.req_wdata = req_wdata;
  assign ifa.rsp_ready = rsp_ready; assign ifb.rsp_ready = rsp_ready;

  wire        rq_ready = sel ? ifb.req_ready : ifa.req_ready;
  wire        rs_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
  wire [31:0] rs_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  wire        rs_err   = sel ? ifb.rsp_err   : ifa.rsp_err;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa.slave)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb.slave)
  );

  // One full transaction with rsp_ready held high. lat = cycles from request
  // presentation to the first cycle rsp_valid is seen, -1 if it never came.
  task automatic xact(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                      input bit sgn, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    lat = -1; rd = 'x; er = 1'bx;
    n = 0;
    while (!rq_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_wen = wen; req_addr = addr; req_size = size; req_sign = sgn; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      n++;
    end while (!rs_valid && n < 50);
    if (rs_valid) begin lat = n; rd = rs_rdata; er = rs_err; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_wen = 1'b0; req_addr = '0; req_size = SIZE_W; req_sign = 1'b0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;
    checks++; if (ifa.req_ready !== 1'b1)  begin errors++; $display("FAIL rst_a_ready got %b want 1", ifa.req_ready); end
    checks++; if (ifa.rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_a_valid got %b want 0", ifa.rsp_valid); end
    checks++; if (ifa.rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_a_rdata got %h want 0", ifa.rsp_rdata); end
    checks++; if (ifa.rsp_err !== 1'b0)    begin errors++; $display("FAIL rst_a_err got %b want 0", ifa.rsp_err); end
    checks++; if (ifb.req_ready !== 1'b1)  begin errors++; $display("FAIL rst_b_ready got %b want 1", ifb.req_ready); end
    checks++; if (ifb.rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_b_valid got %b want 0", ifb.rsp_valid); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, SIZE_W, 1'b0, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 3)       begin errors++; $display("FAIL st_word_lat got %0d want 3", lat); end
    checks++; if (er !== 1'b0)     begin errors++; $display("FAIL st_word_err got %b want 0", er); end
    checks++; if (rd !== 32'd0)    begin errors++; $display("FAIL st_word_rdata got %h want 0", rd); end
    xact(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 3)       begin errors++; $display("FAIL ld_word_lat got %0d want 3", lat); end
    checks++; if (er !== 1'b0)     begin errors++; $display("FAIL ld_word_err got %b want 0", er); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h20, SIZE_W, 1'b0, 32'h11223344, rd, er, lat);
    xact(1'b1, 32'h22, SIZE_B, 1'b0, 32'h000000AA, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_byte_err got %b want 0", er); end
    xact(1'b0, 32'h20, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL lane_word got %h want 11aa3344", rd); end
    xact(1'b0, 32'h22, SIZE_B, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL ld_byte_sx got %h want ffffffaa", rd); end
    xact(1'b0, 32'h22, SIZE_B, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL ld_byte_zx got %h want 000000aa", rd); end
    xact(1'b0, 32'h22, SIZE_H, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000011AA) begin errors++; $display("FAIL ld_half_hi got %h want 000011aa", rd); end
    xact(1'b0, 32'h23, SIZE_B, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL ld_byte3 got %h want 00000011", rd); end
    xact(1'b1, 32'h20, SIZE_H, 1'b0, 32'h0000C0DE, rd, er, lat);
    xact(1'b0, 32'h20, SIZE_H, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFC0DE) begin errors++; $display("FAIL ld_half_lo got %h want ffffc0de", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 32'h21, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_word_ld got err=%b rd=%h want err=1 rd=0", er, rd); end
    xact(1'b1, 32'h23, SIZE_H, 1'b0, 32'h0000BEEF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_half_st got err=%b rd=%h want err=1 rd=0", er, rd); end
    xact(1'b1, 32'h20, SIZE_X, 1'b0, 32'h99999999, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL ill_size_st got err=%b rd=%h want err=1 rd=0", er, rd); end
    xact(1'b0, 32'h20, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h11AAC0DE) begin errors++; $display("FAIL err_no_write got err=%b rd=%h want err=0 rd=11aac0de", er, rd); end
    xact(1'b0, 32'h1000, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_ld got err=%b rd=%h want err=1 rd=0", er, rd); end
    xact(1'b1, 32'hFFC, SIZE_W, 1'b0, 32'hCAFEF00D, rd, er, lat);
    xact(1'b0, 32'hFFC, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word got err=%b rd=%h want err=0 rd=cafef00d", er, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    req_wen = 1'b0; req_addr = 32'h10; req_size = SIZE_W; req_sign = 1'b0; req_wdata = '0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; req_valid = 1'b0; n++; end while (!rs_valid && n < 50);
    checks++; if (rs_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b want 1", rs_valid); end
    // A competing store must be ignored while the response is pending.
    req_wen = 1'b1; req_wdata = 32'h12345678; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (rs_valid !== 1'b1 || rs_rdata !== 32'hDEADBEEF || rs_err !== 1'b0 || rq_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h e=%b r=%b want v=1 d=deadbeef e=0 r=0", i, rs_valid, rs_rdata, rs_err, rq_ready);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rs_valid !== 1'b0 || rq_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", rs_valid, rq_ready); end
    xact(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_ignored_store got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b1;
    xact(1'b1, 32'h30, SIZE_W, 1'b0, 32'h000000C3, rd, er, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL lat4_st got %0d want 5", lat); end
    req_wen = 1'b1; req_addr = 32'h30; req_size = SIZE_W; req_sign = 1'b0; req_wdata = 32'h55;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (rq_ready !== 1'b0) begin errors++; $display("FAIL rw_accepted got ready=%b want 0", rq_ready); end
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    checks++; if (rq_ready !== 1'b1) begin errors++; $display("FAIL rw_ready got %b want 1", rq_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (rs_valid !== 1'b0) begin errors++; $display("FAIL rw_valid cyc %0d got %b want 0", i, rs_valid); end
      @(posedge clk); #1;
    end
    xact(1'b0, 32'h30, SIZE_W, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000C3 || er !== 1'b0) begin errors++; $display("FAIL rw_dropped got rd=%h err=%b want rd=000000c3 err=0", rd, er); end
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
